// File: rtl/nunchuck_input_conditioner.sv
// Nunchuck input conditioner: centre calibration, deadzone, auto-repeat step pulses, button debounce.
// Define NUNCHUCK_DIAGONAL_EN to allow X and Y steps in the same sample (otherwise the dominant axis wins).
module nunchuck_input_conditioner #(
  parameter int unsigned DEADZONE     = 16,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 6,
  parameter int unsigned DEBOUNCE     = 3
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic       z,
  input  logic       c,
  input  logic       cal_req,
  output logic       cal_done,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down,
  output logic       z_press,
  output logic       c_press,
  output logic       z_held,
  output logic       c_held
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned DW      = $clog2(DEBOUNCE + 1);

  localparam logic [7:0]    DZ_C    = 8'(DEADZONE);
  localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);
  localparam logic [DW-1:0] DB_C    = DW'(DEBOUNCE);

  typedef enum logic [1:0] {AX_IDLE, AX_HOLD, AX_REPEAT} ax_state_e;

  typedef struct packed {
    ax_state_e     state;
    logic          neg;    // held direction: 1 = negative (left/down)
    logic [CW-1:0] cnt;
  } axis_t;

  typedef struct packed {
    axis_t nxt;
    logic  p_pos;
    logic  p_neg;
  } axis_res_t;

  typedef struct packed {
    logic          level;
    logic [DW-1:0] cnt;
  } btn_t;

  localparam axis_t AXIS_IDLE = '{state: AX_IDLE, neg: 1'b0, cnt: '0};

  function automatic logic [7:0] mag(input logic [8:0] d);
    logic [8:0] neg_d;
    neg_d = -d;
    return d[8] ? neg_d[7:0] : d[7:0];
  endfunction

  function automatic axis_res_t axis_next(input axis_t cur, input logic pos, input logic neg);
    axis_res_t     res;
    logic [CW-1:0] inc;
    inc       = (cur.cnt == '1) ? cur.cnt : cur.cnt + 1'b1;
    res.nxt   = cur;
    res.p_pos = 1'b0;
    res.p_neg = 1'b0;
    if (!pos && !neg) begin
      res.nxt = AXIS_IDLE;
    end else if (cur.state == AX_IDLE || cur.neg != neg) begin
      // A sign flip is handled exactly like a fresh press from IDLE.
      res.nxt   = '{state: AX_HOLD, neg: neg, cnt: '0};
      res.p_pos = pos;
      res.p_neg = neg;
    end else if (inc == ((cur.state == AX_HOLD) ? DELAY_C : RATE_C)) begin
      res.nxt   = '{state: AX_REPEAT, neg: neg, cnt: '0};
      res.p_pos = pos;
      res.p_neg = neg;
    end else begin
      res.nxt.cnt = inc;
    end
    return res;
  endfunction

  function automatic btn_t btn_next(input btn_t cur, input logic raw);
    btn_t          res;
    logic [DW-1:0] inc;
    inc = (cur.cnt == '1) ? cur.cnt : cur.cnt + 1'b1;
    res = cur;
    if (raw == cur.level) begin
      res.cnt = '0;
    end else if (inc == DB_C) begin
      res.level = raw;
      res.cnt   = '0;
    end else begin
      res.cnt = inc;
    end
    return res;
  endfunction

  logic [7:0] centre_x_q, centre_x_d, centre_y_q, centre_y_d;
  logic       cal_done_q, cal_done_d;
  axis_t      ax_x_q, ax_x_d, ax_y_q, ax_y_d;
  btn_t       btn_z_q, btn_z_d, btn_c_q, btn_c_d;
  logic [3:0] step_q, step_d;    // {left, right, up, down}
  logic [1:0] press_q, press_d;  // {z, c}

  logic [8:0] dx, dy;
  logic [7:0] mx, my;
  logic       act_x, act_y;
  axis_res_t  rx, ry;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    centre_x_d = centre_x_q;
    centre_y_d = centre_y_q;
    cal_done_d = cal_done_q;
    ax_x_d     = ax_x_q;
    ax_y_d     = ax_y_q;
    btn_z_d    = btn_z_q;
    btn_c_d    = btn_c_q;
    step_d     = '0;
    press_d    = '0;

    dx    = {1'b0, stick_x} - {1'b0, centre_x_q};
    dy    = {1'b0, stick_y} - {1'b0, centre_y_q};
    mx    = mag(dx);
    my    = mag(dy);
    act_x = mx > DZ_C;
    act_y = my > DZ_C;
`ifndef NUNCHUCK_DIAGONAL_EN
    if (act_x && act_y) begin
      if (my > mx) act_x = 1'b0;
      else         act_y = 1'b0;
    end
`endif
    rx = axis_next(ax_x_q, act_x & ~dx[8], act_x & dx[8]);
    ry = axis_next(ax_y_q, act_y & ~dy[8], act_y & dy[8]);

    if (cal_req) cal_done_d = 1'b0;

    if (sample_valid) begin
      btn_z_d = btn_next(btn_z_q, z);
      btn_c_d = btn_next(btn_c_q, c);
      if (!cal_done_q || cal_req) begin
        centre_x_d = stick_x;
        centre_y_d = stick_y;
        cal_done_d = 1'b1;
        ax_x_d     = AXIS_IDLE;
        ax_y_d     = AXIS_IDLE;
      end else begin
        ax_x_d  = rx.nxt;
        ax_y_d  = ry.nxt;
        step_d  = {rx.p_neg, rx.p_pos, ry.p_pos, ry.p_neg};
        press_d = {btn_z_d.level & ~btn_z_q.level, btn_c_d.level & ~btn_c_q.level};
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      centre_x_q <= 8'd128;
      centre_y_q <= 8'd128;
      cal_done_q <= 1'b0;
      ax_x_q     <= AXIS_IDLE;
      ax_y_q     <= AXIS_IDLE;
      btn_z_q    <= '0;
      btn_c_q    <= '0;
      step_q     <= '0;
      press_q    <= '0;
    end else begin
      centre_x_q <= centre_x_d;
      centre_y_q <= centre_y_d;
      cal_done_q <= cal_done_d;
      ax_x_q     <= ax_x_d;
      ax_y_q     <= ax_y_d;
      btn_z_q    <= btn_z_d;
      btn_c_q    <= btn_c_d;
      step_q     <= step_d;
      press_q    <= press_d;
    end
  end

  assign cal_done   = cal_done_q;
  assign step_left  = step_q[3];
  assign step_right = step_q[2];
  assign step_up    = step_q[1];
  assign step_down  = step_q[0];
  assign z_press    = press_q[1];
  assign c_press    = press_q[0];
  assign z_held     = btn_z_q.level;
  assign c_held     = btn_c_q.level;

endmodule

// File: tb/tb_nunchuck_input_conditioner.sv
// Directed bench for nunchuck_input_conditioner: calibration, deadzone, auto-repeat, debounce, reset.
// Expectations follow the default build unless NUNCHUCK_DIAGONAL_EN is defined.
module tb_nunchuck_input_conditioner;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] stick_x = 8'd128;
  logic [7:0] stick_y = 8'd128;
  logic       z = 1'b0;
  logic       c = 1'b0;
  logic       cal_req = 1'b0;
  logic       cal_done, step_left, step_right, step_up, step_down;
  logic       z_press, c_press, z_held, c_held;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned tail_bad = 0;
  logic [5:0]  got;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] L    = 6'b100000;
  localparam logic [5:0] R    = 6'b010000;
  localparam logic [5:0] U    = 6'b001000;
  localparam logic [5:0] D    = 6'b000100;
  localparam logic [5:0] ZP   = 6'b000010;
  localparam logic [5:0] CP   = 6'b000001;

  nunchuck_input_conditioner dut (
    .clock(clock), .rst(rst), .sample_valid(sample_valid),
    .stick_x(stick_x), .stick_y(stick_y), .z(z), .c(c), .cal_req(cal_req),
    .cal_done(cal_done), .step_left(step_left), .step_right(step_right),
    .step_up(step_up), .step_down(step_down), .z_press(z_press), .c_press(c_press),
    .z_held(z_held), .c_held(c_held)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] pulses();
    return {step_left, step_right, step_up, step_down, z_press, c_press};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample: pulses land in got; the following cycle must be pulse-free.
  task automatic do_sample(input logic [7:0] x, input logic [7:0] y,
                           input logic zz, input logic cc, input logic cal);
    @(negedge clock);
    stick_x = x; stick_y = y; z = zz; c = cc; cal_req = cal; sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0; cal_req = 1'b0;
    got = pulses();
    @(negedge clock);
    if (pulses() !== NONE) tail_bad++;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("in_reset_outputs", {cal_done, pulses(), z_held, c_held}, 9'h000);
    rst = 1'b1;
    @(negedge clock);
    check("post_reset_cal_done", cal_done, 0);

    // Calibration sample emits nothing; 10 counts off-centre is inside the deadzone.
    do_sample(8'd130, 8'd126, 1'b0, 1'b0, 1'b0);
    check("cal_sample_pulses", got, NONE);
    check("cal_done_set", cal_done, 1);
    do_sample(8'd140, 8'd126, 1'b0, 1'b0, 1'b0);
    check("deadzone_10", got, NONE);

    // Recalibrate at 128 with cal_req on the sample itself.
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b1);
    check("recal_pulses", got, NONE);
    check("recal_cal_done", cal_done, 1);

    // 40 held samples: steps on 1, 21, 27, 33, 39.
    for (int i = 1; i <= 40; i++) begin
      do_sample(8'd200, 8'd128, 1'b0, 1'b0, 1'b0);
      check($sformatf("repeat_s%0d", i), got,
            (i == 1 || i == 21 || i == 27 || i == 33 || i == 39) ? R : NONE);
    end
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    check("release_x", got, NONE);

    // Direction flip re-enters like IDLE.
    do_sample(8'd200, 8'd128, 1'b0, 1'b0, 1'b0);
    check("flip_right", got, R);
    do_sample(8'd50, 8'd128, 1'b0, 1'b0, 1'b0);
    check("flip_left", got, L);
    do_sample(8'd50, 8'd128, 1'b0, 1'b0, 1'b0);
    check("flip_hold", got, NONE);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    do_sample(8'd200, 8'd128, 1'b0, 1'b0, 1'b0);
    check("fresh_after_idle", got, R);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);

    // Deadzone edges: |d| = 16 centred, 17 active.
    do_sample(8'd144, 8'd128, 1'b0, 1'b0, 1'b0);
    check("dz_pos16", got, NONE);
    do_sample(8'd145, 8'd128, 1'b0, 1'b0, 1'b0);
    check("dz_pos17", got, R);
    do_sample(8'd112, 8'd128, 1'b0, 1'b0, 1'b0);
    check("dz_neg16", got, NONE);
    do_sample(8'd111, 8'd128, 1'b0, 1'b0, 1'b0);
    check("dz_neg17", got, L);
    do_sample(8'd128, 8'd200, 1'b0, 1'b0, 1'b0);
    check("y_up", got, U);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);

    // Z debounce: 1,0,1,1,1 then 0,0,0.
    do_sample(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    check("z_s1", got, NONE);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    check("z_s2", got, NONE);
    do_sample(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    do_sample(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    check("z_s4", got, NONE);
    check("z_held_before", z_held, 0);
    do_sample(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    check("z_press", got, ZP);
    check("z_held_set", z_held, 1);
    do_sample(8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    check("z_no_repress", got, NONE);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    check("z_held_still", z_held, 1);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    check("z_release_pulse", got, NONE);
    check("z_held_clear", z_held, 0);

    // C press after three 1s.
    do_sample(8'd128, 8'd128, 1'b0, 1'b1, 1'b0);
    do_sample(8'd128, 8'd128, 1'b0, 1'b1, 1'b0);
    check("c_s2", got, NONE);
    do_sample(8'd128, 8'd128, 1'b0, 1'b1, 1'b0);
    check("c_press", got, CP);
    check("c_held_set", c_held, 1);

    // Diagonal input: X d=72, Y d=-108.
    do_sample(8'd200, 8'd20, 1'b0, 1'b1, 1'b0);
`ifdef NUNCHUCK_DIAGONAL_EN
    check("diag", got, R | D);
`else
    check("diag", got, D);
`endif
    do_sample(8'd128, 8'd128, 1'b0, 1'b1, 1'b0);

    // Reach REPEAT, then reset while a step pulse is high.
    for (int i = 1; i <= 20; i++) do_sample(8'd200, 8'd128, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    check("pre_reset_step", step_right, 1);
    #2 rst = 1'b0;
    #1 check("reset_async_outputs", {cal_done, pulses(), z_held, c_held}, 9'h000);
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset2_cal_done", cal_done, 0);
    check("post_reset2_pulses", pulses(), NONE);
    do_sample(8'd200, 8'd128, 1'b0, 1'b0, 1'b0);
    check("recal_after_reset", got, NONE);
    check("recal_after_reset_done", cal_done, 1);
    do_sample(8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    check("new_centre_left", got, L);

    check("pulse_width_one_cycle", tail_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
